rect_plot_scheduler: RTL and testbench
======================================

// Module: rect_plot_scheduler
// PURPOSE
//   Shares the single VGA pixel-write port (x, y, colour, plot into vga_adapter) between NREQ drawing
//   clients (snake-segment draw, tail erase, apple draw). Each client requests a filled WxH rectangle.
//   The block grants one client at a time, round-robin, and emits one pixel write per clock.
//   It replaces the per-client XC/YC counter + plot FSM pairs.
// PARAMETERS
//   NREQ     3    number of requesting clients
//   XW       8    x coordinate width (160-wide screen)
//   YW       7    y coordinate width (120-high screen)
//   CW       3    colour width
//   DW       4    rectangle dimension width; w,h range 0..15
//   XSCREEN  160  pixels with x >= XSCREEN are clipped
//   YSCREEN  120  pixels with y >= YSCREEN are clipped
// PORTS
//   CLOCK_50  in   1         system clock; all state changes on its rising edge
//   reset     in   1         synchronous, active-high reset
//   req       in   NREQ      per-client request; hold high until that client's done
//   req_x     in   NREQ*XW   packed rect origin x; client i at [i*XW +: XW]
//   req_y     in   NREQ*YW   packed rect origin y
//   req_w     in   NREQ*DW   packed rect width
//   req_h     in   NREQ*DW   packed rect height
//   req_col   in   NREQ*CW   packed rect colour
//   grant     out  NREQ      one-hot; the client being served, held high through DRAW and DONE
//   done      out  1         one-cycle pulse in DONE; the client flagged in grant is finished
//   busy      out  1         high in all states except IDLE
//   x         out  XW        pixel x to vga_adapter
//   y         out  YW        pixel y to vga_adapter
//   colour    out  CW        pixel colour to vga_adapter
//   plot      out  1         pixel write enable to vga_adapter
// BEHAVIOUR
//   Reset: state=IDLE; grant=0; done=0; busy=0; plot=0; x=0; y=0; colour=0; rr pointer=0; xc=yc=0.
//     Reset takes effect in any state and abandons a rectangle mid-draw; no further plots occur.
//   FSM states: IDLE -> DRAW -> DONE -> IDLE.
//   IDLE: req is sampled only here. If req!=0, the winner is the first set bit at or above rr,
//     wrapping modulo NREQ. On the edge, latch the winner's x0,y0,w,h,col; set grant; xc=yc=0.
//     If w==0 or h==0, go to DONE; otherwise go to DRAW.
//   DRAW: plot=1 every cycle; x=x0+xc and y=y0+yc; colour is the latched col.
//     Scan order is row-major. xc runs 0..w-1; at xc==w-1, xc returns to 0 and yc increments.
//     After the pixel at (w-1,h-1), go to DONE. Exactly w*h DRAW cycles, no bubbles.
//   DONE: done=1, plot=0, grant still held; rr=winner+1 mod NREQ; next state IDLE.
//   Latency: req seen in IDLE cycle t -> first pixel in cycle t+1 -> done in cycle t+1+w*h.
//     An idle-to-idle service takes w*h+2 cycles.
//   Requests: deassertion of req during DRAW is ignored and the rectangle completes.
//     Input fields may change after the grant edge; the latched copies are used.
//     A req still high in the IDLE following done is treated as a new request.
//   Arithmetic: x0+xc is computed at XW+1 bits and y0+yc at YW+1 bits.
//     If the sum >= XSCREEN (or >= YSCREEN), plot=0 for that cycle; the scan still advances,
//     so clipping never changes cycle count. x and y outputs carry the truncated sum.
//   Outputs are combinational from registered state only; there is no req-to-output path.
// TESTING
//   1. req=001, x=10, y=20, w=2, h=2, col=100 -> plots (10,20),(11,20),(10,21),(11,21) on 4
//      consecutive cycles; then done with grant=001; busy low the next cycle.
//   2. From reset, req=111, all w=h=1 and held -> grants 001, 010, 100, 001 in order;
//      each service is 3 cycles.
//   3. req[0] always high and req[2] high, rr=0 -> services alternate 0, 2, 0, 2;
//      neither client is served twice in a row while the other waits.
//   4. req=010 with w=0, h=5 -> no plot; done 1 cycle after the grant edge; rr becomes 2.
//   5. x=158, y=118, w=4, h=3 -> 12 DRAW cycles; plot=1 only for x in {158,159} and
//      y in {118,119} (4 pixels).
//   6. reset pulsed in the 3rd DRAW cycle of a 4x4 rect -> next cycle plot=0, grant=0,
//      busy=0, rr=0, and no done pulse.

Source files
------------

// File: rtl/rect_plot_scheduler.sv
// Round-robin rectangle plotter: arbitrates NREQ drawing clients onto one
// VGA pixel-write port, scanning each granted WxH rectangle row-major at one
// pixel per clock, with off-screen pixels suppressed but still clocked.
module rect_plot_scheduler #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned XW      = 8,
  parameter int unsigned YW      = 7,
  parameter int unsigned CW      = 3,
  parameter int unsigned DW      = 4,
  parameter int unsigned XSCREEN = 160,
  parameter int unsigned YSCREEN = 120
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*XW-1:0] req_x,
  input  logic [NREQ*YW-1:0] req_y,
  input  logic [NREQ*DW-1:0] req_w,
  input  logic [NREQ*DW-1:0] req_h,
  input  logic [NREQ*CW-1:0] req_col,
  output logic [NREQ-1:0]    grant,
  output logic               done,
  output logic               busy,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic [CW-1:0]      colour,
  output logic               plot
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

  state_e        r_state, w_state_next;
  logic [IW-1:0] r_rr, r_win, w_pick;
  logic          w_found;
  logic [XW-1:0] r_x0;
  logic [YW-1:0] r_y0;
  logic [DW-1:0] r_w, r_h, r_xc, r_yc;
  logic [CW-1:0] r_col;
  logic [DW-1:0] w_sel_w, w_sel_h;
  logic          w_xc_last, w_yc_last;
  logic [XW:0]   w_xs;
  logic [YW:0]   w_ys;

  // Round-robin pick: first requesting client at or above r_rr, wrapping.
  always_comb begin : p_arb
    int unsigned idx;
    logic [IW-1:0] cand;
    idx     = 0;
    cand    = '0;
    w_pick  = r_rr;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IW'(idx);
      if (!w_found && req[cand]) begin
        w_found = 1'b1;
        w_pick  = cand;
      end
    end
  end

  assign w_sel_w   = req_w[w_pick*DW +: DW];
  assign w_sel_h   = req_h[w_pick*DW +: DW];
  assign w_xc_last = (r_xc == r_w - DW'(1));
  assign w_yc_last = (r_yc == r_h - DW'(1));
  // One extra bit so a sum past the coordinate range still registers as off-screen.
  assign w_xs      = {1'b0, r_x0} + (XW+1)'(r_xc);
  assign w_ys      = {1'b0, r_y0} + (YW+1)'(r_yc);

  // Next-state logic for the IDLE -> DRAW -> DONE cycle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_next = ((w_sel_w == '0) || (w_sel_h == '0)) ? StDone : StDraw;
        end
      end
      StDraw: begin
        if (w_xc_last && w_yc_last) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // State, latched request fields, scan counters and round-robin pointer.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= StIdle;
      r_rr    <= '0;
      r_win   <= '0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_col   <= '0;
      r_xc    <= '0;
      r_yc    <= '0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_win <= w_pick;
            r_x0  <= req_x[w_pick*XW +: XW];
            r_y0  <= req_y[w_pick*YW +: YW];
            r_w   <= w_sel_w;
            r_h   <= w_sel_h;
            r_col <= req_col[w_pick*CW +: CW];
            r_xc  <= '0;
            r_yc  <= '0;
          end
        end
        StDraw: begin
          if (w_xc_last) begin
            r_xc <= '0;
            if (!w_yc_last) r_yc <= r_yc + DW'(1);
          end else begin
            r_xc <= r_xc + DW'(1);
          end
        end
        StDone: begin
          r_rr <= (r_win == IW'(NREQ - 1)) ? '0 : r_win + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only; pixels off-screen are not plotted.
  always_comb begin
    grant  = '0;
    done   = 1'b0;
    busy   = (r_state != StIdle);
    x      = '0;
    y      = '0;
    colour = '0;
    plot   = 1'b0;
    if (r_state != StIdle) grant = NREQ'(1) << r_win;
    if (r_state == StDone) done = 1'b1;
    if (r_state == StDraw) begin
      x      = w_xs[XW-1:0];
      y      = w_ys[YW-1:0];
      colour = r_col;
      plot   = (w_xs < (XW+1)'(XSCREEN)) && (w_ys < (YW+1)'(YSCREEN));
    end
  end

endmodule

// File: tb/tb_rect_plot_scheduler.sv
// Self-checking bench for rect_plot_scheduler: table of single-shot requests
// plus hand-written round-robin and mid-draw reset sequences. Expected pixels
// go into a scoreboard queue and are popped as the DUT plots.
module tb_rect_plot_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req = '0;
  logic [23:0] req_x = '0;
  logic [20:0] req_y = '0;
  logic [11:0] req_w = '0;
  logic [11:0] req_h = '0;
  logic [8:0]  req_col = '0;
  logic [2:0] grant;
  logic       done, busy, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  always #5 clk = ~clk;

  rect_plot_scheduler dut (
    .CLOCK_50(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_col(req_col), .grant(grant), .done(done),
    .busy(busy), .x(x), .y(y), .colour(colour), .plot(plot)
  );

  typedef struct {
    logic [2:0] rq;
    int x, y, w, h, col;
    int win;    // expected granted client
    int plots;  // expected on-screen pixel count
  } vec_t;

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_e;
  vec_t vecs[8];
  int n_checks = 0;
  int n_errors = 0;
  int n_plots  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Plot monitor: every plotted pixel must match the head of the scoreboard.
  always @(negedge clk) begin
    if (plot) begin
      n_plots++;
      if (exp_q.size() == 0) begin
        check("unexpected_plot", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pix_x", int'(x), int'(mon_e.px));
        check("pix_y", int'(y), int'(mon_e.py));
        check("pix_colour", int'(colour), int'(mon_e.pc));
      end
    end
  end

  // Same geometry for every client; colour differs per client (col ^ index).
  task automatic set_fields(input logic [2:0] r, input int px, input int py, input int pw,
                            input int ph, input int pcol);
    for (int c = 0; c < 3; c++) begin
      req_x[c*8 +: 8]   = px[7:0];
      req_y[c*7 +: 7]   = py[6:0];
      req_w[c*4 +: 4]   = pw[3:0];
      req_h[c*4 +: 4]   = ph[3:0];
      req_col[c*3 +: 3] = pcol[2:0] ^ c[2:0];
    end
    req = r;
  endtask

  task automatic push_rect(input int px, input int py, input int pw, input int ph,
                           input int pc, input int limit);
    int n;
    pix_t p;
    n = 0;
    for (int j = 0; j < ph; j++) begin
      for (int i = 0; i < pw; i++) begin
        if (n < limit && (px + i) < 160 && (py + j) < 120) begin
          p.px = 8'(px + i);
          p.py = 7'(py + j);
          p.pc = 3'(pc);
          exp_q.push_back(p);
        end
        n++;
      end
    end
  endtask

  task automatic wait_done(output int cycles, output int draws, output logic [2:0] g,
                           output bit ok);
    ok = 1'b0;
    cycles = 0;
    draws = 0;
    g = '0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      cycles++;
      if (done) begin
        g = grant;
        ok = 1'b1;
      end else if (busy) begin
        draws++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, drw;
    logic [2:0] g;
    bit ok;
    @(negedge clk);
    n_plots = 0;
    set_fields(v.rq, v.x, v.y, v.w, v.h, v.col);
    push_rect(v.x, v.y, v.w, v.h, (v.col ^ v.win) & 7, 1000);
    wait_done(cyc, drw, g, ok);
    req = '0;
    check("done_seen", int'(ok), 1);
    check("vec_grant", int'(g), 1 << v.win);
    check("vec_draw_cycles", drw, v.w * v.h);
    check("vec_plot_count", n_plots, v.plots);
    @(negedge clk);
    check("vec_busy_after", int'(busy), 0);
    check("vec_plot_after", int'(plot), 0);
  endtask

  // Drive req with w=h=1 held and expect the given winner order.
  task automatic rr_seq(input logic [2:0] r, input int o0, input int o1, input int o2,
                        input int o3);
    int ord[4];
    int cyc, drw;
    logic [2:0] g;
    bit ok;
    ord = '{o0, o1, o2, o3};
    do_reset();
    @(negedge clk);
    set_fields(r, 20, 30, 1, 1, 6);
    for (int k = 0; k < 4; k++) push_rect(20, 30, 1, 1, (6 ^ ord[k]) & 7, 1);
    for (int k = 0; k < 4; k++) begin
      wait_done(cyc, drw, g, ok);
      if (k == 3) req = '0;
      check("rr_done_seen", int'(ok), 1);
      check("rr_grant", int'(g), 1 << ord[k]);
      check("rr_draw_cycles", drw, 1);
      if (k > 0) check("rr_service_cycles", cyc, 3);
    end
    @(negedge clk);
    check("rr_busy_after", int'(busy), 0);
  endtask

  initial begin
    int cyc, drw, nd;
    logic [2:0] g;
    bit ok;
    vec_t v;

    vecs[0] = '{3'b001,  10,  20,  2,  2, 4, 0,  4};
    vecs[1] = '{3'b010,   5,   6,  0,  5, 3, 1,  0};
    vecs[2] = '{3'b111,   1,   1,  1,  1, 2, 2,  1};
    vecs[3] = '{3'b110,  30,  40,  3,  1, 5, 1,  3};
    vecs[4] = '{3'b011, 158, 118,  4,  3, 7, 0,  4};
    vecs[5] = '{3'b100, 159,   0,  2,  2, 1, 2,  2};
    vecs[6] = '{3'b001, 255, 127,  2,  2, 3, 0,  0};
    vecs[7] = '{3'b001,   0, 119, 15, 15, 6, 0, 15};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_grant", int'(grant), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_xy_col", int'({x, y, colour}), 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    rr_seq(3'b111, 0, 1, 2, 0);
    rr_seq(3'b101, 0, 2, 0, 2);

    // Move rr off zero, then reset in the 3rd DRAW cycle of a 4x4 rect.
    v = '{3'b001, 7, 7, 1, 1, 2, 0, 1};
    run_vec(v);
    @(negedge clk);
    set_fields(3'b010, 50, 60, 4, 4, 5);
    push_rect(50, 60, 4, 4, 5 ^ 1, 3);
    repeat (3) @(negedge clk);
    check("mid_busy_before", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    check("mid_plot", int'(plot), 0);
    check("mid_grant", int'(grant), 0);
    check("mid_busy", int'(busy), 0);
    check("mid_done", int'(done), 0);
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || plot) nd++;
    end
    check("mid_no_done_after", nd, 0);
    set_fields(3'b111, 70, 80, 1, 1, 0);
    push_rect(70, 80, 1, 1, 0, 1);
    wait_done(cyc, drw, g, ok);
    req = '0;
    check("mid_rr_cleared", int'(g), 3'b001);
    @(negedge clk);

    check("leftover_pixels", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
